zbt_pixel_packer: RTL and testbench

Parametrised packer that turns an already-synchronised pixel stream (post colour-space conversion, system clock domain) into ZBT write transactions. It fixes pixel-to-address alignment so that pixel (0,0) is always at word 0 of row 0, and flushes partial words at line end. It adds optional 2:1 horizontal decimation and buffers completed words in a small FIFO with a valid/ready handshake toward the ZBT arbiter. It sits between the colour converter and the ZBT write port, replacing the fixed 2-pixel/36-bit NTSC packer.

---
 rtl/zbt_pixel_packer_if.sv | 29 ++
 rtl/zbt_pixel_packer.sv | 191 +++++++++++++++++++
 tb/tb_zbt_pixel_packer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/zbt_pixel_packer_if.sv
// zbt_pixel_packer_if: pixel-stream input and ZBT write-port bundle for the
// pixel packer. The slave modport is the packer's view; the master modport is
// the view of the surrounding logic (colour converter + ZBT arbiter).
interface zbt_pixel_packer_if #(
  parameter int PIX_W  = 18,
  parameter int WORD_W = 36,
  parameter int ADDR_W = 19
);
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_sol;
  logic              pix_sof;
  logic              pix_field;
  logic              decim;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output pix_valid, pix_data, pix_sol, pix_sof, pix_field, decim, wr_ready,
    input  wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  pix_valid, pix_data, pix_sol, pix_sof, pix_field, decim, wr_ready,
    output wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/zbt_pixel_packer.sv
// zbt_pixel_packer: packs a synchronised pixel stream into ZBT write words.
// Pixel (0,0) of each field lands in slot 0 of word 0, partial words are
// flushed by the next start-of-line pixel, optional 2:1 horizontal decimation
// is selected per line, and completed words queue in a small output FIFO.
// Optional feature macro: PACKER_STATS_EN adds words_dropped / fields_seen.
module zbt_pixel_packer #(
  parameter int PIX_W        = 18,
  parameter int PIX_PER_WORD = 2,
  parameter int WORD_W       = 36,
  parameter int LINE_PIX     = 1024,
  parameter int ROWS         = 384,
  parameter int Y_W          = 9,
  parameter int ADDR_W       = 19,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  zbt_pixel_packer_if.slave     bus,
  output logic                  overflow
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]           words_dropped,
  output logic [15:0]           fields_seen
`endif
);

  localparam int PACK_W  = PIX_W * PIX_PER_WORD;
  localparam int SLOT_SH = $clog2(PIX_PER_WORD);
  localparam int IDX_W   = $clog2(LINE_PIX / PIX_PER_WORD);
  localparam int PX_W    = $clog2(LINE_PIX) + 1;  // holds LINE_PIX itself
  localparam int ROW_W   = Y_W + 1;               // holds ROWS itself
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } entry_t;

  // Line / field state
  logic              started;
  logic [PX_W-1:0]   in_x_q;
  logic [PX_W-1:0]   px_q;
  logic [ROW_W-1:0]  row_q;
  logic              field_q;
  logic              decim_q;
  logic              pend_valid;
  logic [PACK_W-1:0] pend_data;
  logic [ADDR_W-1:0] pend_addr;

  // Per-pixel combinational view
  logic              acc, sol_acc, sof_acc;
  logic [PX_W-1:0]   in_x_cur, px_cur;
  logic [ROW_W-1:0]  row_cur;
  logic              field_cur, decim_cur;
  logic              packed_pix, keep, complete, flush, push_req;
  int                slot;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] addr_cur;
  logic [PACK_W-1:0] new_data;
  entry_t            push_entry;

  // FIFO state
  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, pop, push_ok, drop;
  entry_t            head;

  // Decode the current pixel: line/field context, slot, address and word image
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc       = bus.pix_valid & (started | bus.pix_sof);
    sol_acc   = acc & bus.pix_sol;
    sof_acc   = acc & bus.pix_sof;
    in_x_cur  = in_x_q;
    px_cur    = px_q;
    row_cur   = row_q;
    field_cur = field_q;
    decim_cur = decim_q;
    if (sol_acc) begin
      in_x_cur  = '0;
      px_cur    = '0;
      decim_cur = bus.decim;
      field_cur = bus.pix_sof ? bus.pix_field : field_q;
      if (bus.pix_sof)
        row_cur = '0;
      else if (row_q >= ROW_W'(ROWS))
        row_cur = row_q;
      else
        row_cur = row_q + 1'b1;
    end
    packed_pix = !decim_cur || !in_x_cur[0];
    keep       = acc && packed_pix && (px_cur < PX_W'(LINE_PIX))
                 && (row_cur < ROW_W'(ROWS));
    slot       = int'(px_cur & PX_W'(PIX_PER_WORD - 1));
    idx        = IDX_W'(px_cur >> SLOT_SH);
    addr_cur   = {row_cur[Y_W-1:0], field_cur, idx};
    new_data   = (slot == 0) ? '0 : pend_data;
    for (int s = 0; s < PIX_PER_WORD; s++)
      if (slot == s) new_data[PACK_W-1-s*PIX_W -: PIX_W] = bus.pix_data;
    complete   = keep && (slot == PIX_PER_WORD - 1);
    // A sol pixel always lands in slot 0, so a flush and a completion can
    // only coincide when PIX_PER_WORD=1, where no partial word ever exists.
    flush      = sol_acc && pend_valid;
    push_req   = flush || complete;
    push_entry = flush ? '{addr: pend_addr, data: WORD_W'(pend_data)}
                       : '{addr: addr_cur,  data: WORD_W'(new_data)};
  end

  // Advance line/field counters and the pending partial word on each accepted pixel
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      started    <= 1'b0;
      in_x_q     <= '0;
      px_q       <= '0;
      row_q      <= '0;
      field_q    <= 1'b0;
      decim_q    <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_addr  <= '0;
    end else if (acc) begin
      started <= 1'b1;
      in_x_q  <= in_x_cur + 1'b1;  // wraps harmlessly: only its parity matters
      px_q    <= (packed_pix && px_cur < PX_W'(LINE_PIX)) ? px_cur + 1'b1 : px_cur;
      row_q   <= row_cur;
      field_q <= field_cur;
      decim_q <= decim_cur;
      if (keep) begin
        pend_valid <= !complete;
        pend_data  <= new_data;
        pend_addr  <= addr_cur;
      end else if (sol_acc) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop     = bus.wr_valid & bus.wr_ready;
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & ~push_ok;

  // FIFO storage: written on accepted pushes only
  always_ff @(posedge clk) begin
    // NOTE: storage is left unreset; occupancy is reset and the outputs are gated by wr_valid.
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (sof_acc)
        overflow <= 1'b0;
    end
  end

  assign head         = mem[rd_ptr];
  assign bus.wr_valid = (count != '0);
  assign bus.wr_addr  = bus.wr_valid ? head.addr : '0;
  assign bus.wr_data  = bus.wr_valid ? head.data : '0;

`ifdef PACKER_STATS_EN
  // Statistics: saturating lost-word count and wrapping field count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_dropped <= '0;
      fields_seen   <= '0;
    end else begin
      if (drop && words_dropped != 16'hFFFF) words_dropped <= words_dropped + 1'b1;
      if (sof_acc) fields_seen <= fields_seen + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_zbt_pixel_packer.sv
// tb_zbt_pixel_packer: directed stimulus with a scoreboard queue; a monitor
// pops and compares every word the packer hands to the arbiter.
module tb_zbt_pixel_packer;

  localparam int PIX_W  = 18;
  localparam int WORD_W = 36;
  localparam int ADDR_W = 19;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic overflow;
`ifdef PACKER_STATS_EN
  logic [15:0] words_dropped;
  logic [15:0] fields_seen;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  zbt_pixel_packer_if #(.PIX_W(PIX_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  zbt_pixel_packer dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .overflow      (overflow)
`ifdef PACKER_STATS_EN
    ,
    .words_dropped (words_dropped),
    .fields_seen   (fields_seen)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input int row, input int field, input int idx);
    return ADDR_W'((row << 10) | (field << 9) | idx);
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return {a, b};
  endfunction

  task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Drive one pixel for one clock; returns 1 time unit after the edge.
  task automatic pix(input logic [PIX_W-1:0] d, input bit sol = 0, input bit sof = 0,
                     input bit fld = 0);
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_sol   = sol;
    bus.pix_sof   = sof;
    bus.pix_field = fld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.pix_valid = 1'b0;
    bus.pix_sol   = 1'b0;
    bus.pix_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    bus.pix_valid = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.wr_valid) break;
    end
    if (n == 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  // Monitor: a word is consumed on each edge where wr_valid & wr_ready hold
  always @(negedge clk) begin
    if (!rst && bus.wr_valid && bus.wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got addr %0h data %0h, expected no word",
                 bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
        check("word_data", 64'(bus.wr_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_sol   = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_field = 1'b0;
    bus.decim     = 1'b0;
    bus.wr_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    check("rst_wr_addr",  64'(bus.wr_addr),  64'd0);
    check("rst_wr_data",  64'(bus.wr_data),  64'd0);
    check("rst_overflow", 64'(overflow),     64'd0);
    rst = 1'b0;
    bus.wr_ready = 1'b1;

    // Pixels before the first sof are dropped
    pix(18'h3AAAA, 1); pix(18'h3BBBB); idle(4);

    // Basic packing, field 1
    expect_word(mk_addr(0, 1, 0), mk_word(18'h00001, 18'h00002));
    expect_word(mk_addr(0, 1, 1), mk_word(18'h00003, 18'h00004));
    pix(18'h00001, 1, 1, 1);
    pix(18'h00002);
    check("latency_wr_valid", 64'(bus.wr_valid), 64'd1);
    pix(18'h00003); pix(18'h00004);
    idle(4);

    // Partial flush: three pixels on row 1, then a sol pixel
    expect_word(mk_addr(1, 1, 0), mk_word(18'h00011, 18'h00012));
    pix(18'h00011, 1); pix(18'h00012); pix(18'h00013);
    idle(4);
    check("empty_before_flush", 64'(bus.wr_valid), 64'd0);
    expect_word(mk_addr(1, 1, 1), mk_word(18'h00013, 18'h00000));
    expect_word(mk_addr(2, 1, 0), mk_word(18'h00021, 18'h00022));
    pix(18'h00021, 1);
    check("flush_same_cycle", 64'(bus.wr_valid), 64'd1);
    pix(18'h00022);
    idle(4);

    // Decimation on row 3
    bus.decim = 1'b1;
    expect_word(mk_addr(3, 1, 0), mk_word(18'd1, 18'd3));
    expect_word(mk_addr(3, 1, 1), mk_word(18'd5, 18'd7));
    for (int i = 1; i <= 8; i++) pix(PIX_W'(i), i == 1);
    bus.decim = 1'b0;
    drain();

    // Backpressure: 12 pixels, 6 words, FIFO of 4
    bus.wr_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      expect_word(mk_addr(0, 0, k), mk_word(PIX_W'(18'h100 + 2*k), PIX_W'(18'h101 + 2*k)));
    for (int i = 0; i < 12; i++) begin
      pix(PIX_W'(18'h100 + i), i == 0, i == 0, 0);
      if (i == 8) check("overflow_before_5th", 64'(overflow), 64'd0);
      if (i == 9) check("overflow_after_5th",  64'(overflow), 64'd1);
    end
    check("bp_wr_valid",  64'(bus.wr_valid), 64'd1);
    check("bp_head_addr", 64'(bus.wr_addr), 64'(mk_addr(0, 0, 0)));
    check("bp_head_data", 64'(bus.wr_data), 64'(mk_word(18'h100, 18'h101)));
`ifdef PACKER_STATS_EN
    check("words_dropped", 64'(words_dropped), 64'd2);
`endif
    bus.wr_ready = 1'b1;
    drain();
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Bounds: 1030-pixel line on row 0 of field 1; sof clears overflow
    for (int k = 0; k < 512; k++)
      expect_word(mk_addr(0, 1, k), mk_word(PIX_W'(2*k), PIX_W'(2*k + 1)));
    pix(18'd0, 1, 1, 1);
    check("overflow_cleared_by_sof", 64'(overflow), 64'd0);
    for (int i = 1; i < 1030; i++) pix(PIX_W'(i));
    // 399 further lines; rows from 384 upward must be dropped
    for (int r = 1; r < 400; r++) begin
      if (r < 384) expect_word(mk_addr(r, 1, 0), mk_word(PIX_W'(2*r), PIX_W'(2*r + 1)));
      pix(PIX_W'(2*r), 1);
      pix(PIX_W'(2*r + 1));
    end
    drain();
`ifdef PACKER_STATS_EN
    check("fields_seen", 64'(fields_seen), 64'd3);
`endif

    // Reset mid-line: 2 words queued, one pixel pending
    bus.wr_ready = 1'b0;
    pix(18'h50, 1, 1, 0); pix(18'h51); pix(18'h52); pix(18'h53); pix(18'h54);
    idle(1);
    check("pre_rst_wr_valid", 64'(bus.wr_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_wr_valid", 64'(bus.wr_valid), 64'd0);
    check("rst_mid_wr_data",  64'(bus.wr_data),  64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.wr_ready = 1'b1;
`ifdef PACKER_STATS_EN
    check("words_dropped_rst", 64'(words_dropped), 64'd0);
`endif
    pix(18'h60, 1); pix(18'h61); pix(18'h62);
    idle(5);
    expect_word(mk_addr(0, 0, 0), mk_word(18'h70, 18'h71));
    pix(18'h70, 1, 1, 0); pix(18'h71);
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
